// File: rtl/mac_dot_lanes.sv
// Multi-lane fixed-point dot-product MAC: products in stage 1, lane sum accumulated in stage 2, result 3 cycles after the last beat.
// Input stalls (s_ready=0) from the last beat until the result is taken; the result holds while m_ready is low.
module mac_dot_lanes #(
  parameter int LANES      = 4,
  parameter int A_INT      = 8,
  parameter int A_FRAC     = 8,
  parameter int B_INT      = 8,
  parameter int B_FRAC     = 8,
  parameter int OUT_INT    = 16,
  parameter int OUT_FRAC   = 16,
  parameter int GUARD_BITS = 9,
  parameter int SAT_EN     = 1,
  parameter int ROUND_EN   = 0,
  parameter int CNT_W      = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic                               s_last,
  input  logic [LANES*(A_INT+A_FRAC)-1:0]    s_a,
  input  logic [LANES*(B_INT+B_FRAC)-1:0]    s_b,
  output logic [OUT_INT+OUT_FRAC-1:0]        m_data,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic                               m_overflow,
  output logic                               m_underflow,
  output logic [CNT_W-1:0]                   m_count
);

  localparam int AW    = A_INT + A_FRAC;
  localparam int BW    = B_INT + B_FRAC;
  localparam int PW    = AW + BW;
  localparam int PF    = A_FRAC + B_FRAC;
  localparam int LW    = $clog2(LANES);
  localparam int ACC_W = PW + LW + GUARD_BITS;
  localparam int OW    = OUT_INT + OUT_FRAC;
  localparam int SH    = PF - OUT_FRAC;
  localparam int RSH   = (SH > 0) ? SH - 1 : 0;
  localparam int EW    = ACC_W + OW + 2;

  localparam logic signed [EW-1:0] RND_ADD = (ROUND_EN != 0 && SH > 0) ? (EW'(1) << RSH) : '0;
  localparam logic signed [EW-1:0] OMAX    = (EW'(1) << (OW - 1)) - EW'(1);
  localparam logic signed [EW-1:0] OMIN    = ~OMAX;

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  logic [1:0]              state_q, state_d;
  logic                    drain_q, drain_d;
  logic signed [PW-1:0]    prod_d [LANES];
  logic signed [PW-1:0]    prod_q [LANES];
  logic                    prod_vld_q;
  logic signed [ACC_W-1:0] lane_sum;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    accept, load, clear;

  logic signed [EW-1:0]    ext, rnd, shf;
  logic                    ovf, unf;
  logic [OW-1:0]           conv;

  logic [OW-1:0]           m_data_q;
  logic                    m_valid_q, m_ovf_q, m_unf_q;
  logic [CNT_W-1:0]        m_count_q;

  assign s_ready = (state_q == ST_ACCUM);
  assign accept  = s_valid && s_ready;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [AW-1:0] a_l;
    logic signed [BW-1:0] b_l;
    assign a_l       = s_a[g*AW +: AW];
    assign b_l       = s_b[g*BW +: BW];
    assign prod_d[g] = PW'(a_l) * PW'(b_l);
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) lane_sum = lane_sum + ACC_W'(prod_q[i]);
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    clear   = 1'b0;
    if (prod_vld_q) acc_d = acc_q + lane_sum;
    case (state_q)
      ST_ACCUM: begin
        if (accept && cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (accept && s_last) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (drain_q) begin
          state_d = ST_OUT;
          load    = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          state_d = ST_ACCUM;
          clear   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // Rounding happens in the widened domain so a carry out of the accumulator range is still caught by saturation.
  always_comb begin
    ext = EW'(acc_q);
    rnd = ext + RND_ADD;
    shf = rnd >>> SH;
    ovf = (shf > OMAX);
    unf = (shf < OMIN);
    if (SAT_EN != 0 && ovf)      conv = OMAX[OW-1:0];
    else if (SAT_EN != 0 && unf) conv = OMIN[OW-1:0];
    else                         conv = shf[OW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ACCUM;
      drain_q    <= 1'b0;
      prod_vld_q <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_ovf_q    <= 1'b0;
      m_unf_q    <= 1'b0;
      m_count_q  <= '0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      prod_vld_q <= accept;
      if (accept) begin
        for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
      end
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      if (load) begin
        m_data_q  <= conv;
        m_ovf_q   <= ovf;
        m_unf_q   <= unf;
        m_count_q <= cnt_q;
        m_valid_q <= 1'b1;
      end else if (clear) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign m_overflow  = m_ovf_q;
  assign m_underflow = m_unf_q;
  assign m_count     = m_count_q;

endmodule

// File: tb/tb_mac_dot_lanes.sv
// Bench for mac_dot_lanes: four LANES=2 variants (saturate, wrap, round to Q.8, truncate to Q.8) share one stimulus stream.
module tb_mac_dot_lanes;

  logic        clk = 1'b0;
  logic        reset, s_valid, s_last, m_ready;
  logic [31:0] s_a, s_b;
  logic [3:0]  rdy, vld, ovf, unf;
  logic [31:0] data0, data1;
  logic [23:0] data2, data3;
  logic [15:0] cnt [4];
  logic [31:0] dat [4];

  always #5 clk = ~clk;

  assign dat[0] = data0;
  assign dat[1] = data1;
  assign dat[2] = {8'h00, data2};
  assign dat[3] = {8'h00, data3};

  mac_dot_lanes #(.LANES(2)) u_sat (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(rdy[0]), .s_last(s_last),
    .s_a(s_a), .s_b(s_b), .m_data(data0), .m_valid(vld[0]), .m_ready(m_ready),
    .m_overflow(ovf[0]), .m_underflow(unf[0]), .m_count(cnt[0]));

  mac_dot_lanes #(.LANES(2), .SAT_EN(0)) u_wrap (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(rdy[1]), .s_last(s_last),
    .s_a(s_a), .s_b(s_b), .m_data(data1), .m_valid(vld[1]), .m_ready(m_ready),
    .m_overflow(ovf[1]), .m_underflow(unf[1]), .m_count(cnt[1]));

  mac_dot_lanes #(.LANES(2), .OUT_FRAC(8), .ROUND_EN(1)) u_rnd (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(rdy[2]), .s_last(s_last),
    .s_a(s_a), .s_b(s_b), .m_data(data2), .m_valid(vld[2]), .m_ready(m_ready),
    .m_overflow(ovf[2]), .m_underflow(unf[2]), .m_count(cnt[2]));

  mac_dot_lanes #(.LANES(2), .OUT_FRAC(8)) u_trn (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(rdy[3]), .s_last(s_last),
    .s_a(s_a), .s_b(s_b), .m_data(data3), .m_valid(vld[3]), .m_ready(m_ready),
    .m_overflow(ovf[3]), .m_underflow(unf[3]), .m_count(cnt[3]));

  typedef struct {
    longint acc;
    int     cnt;
  } exp_t;

  exp_t   sb[$];
  longint acc_m;
  int     cnt_m;
  int     total = 0;
  int     bad   = 0;

  // per-variant output format: shift, width, saturate, round
  int cfg_sh  [4] = '{0, 0, 8, 8};
  int cfg_ow  [4] = '{32, 32, 24, 24};
  bit cfg_sat [4] = '{1, 0, 1, 1};
  bit cfg_rnd [4] = '{0, 0, 1, 0};

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint prod(input logic [15:0] a, input logic [15:0] b);
    logic signed [15:0] sa, sb_;
    sa  = a;
    sb_ = b;
    return longint'(sa) * longint'(sb_);
  endfunction

  function automatic void conv(input longint acc, input int sh, input int ow, input bit sat,
                               input bit rnd, output longint d, output bit ov, output bit un);
    longint v, mx, mn;
    v = acc;
    if (rnd && sh > 0) v = v + (longint'(1) <<< (sh - 1));
    v  = v >>> sh;
    mx = (longint'(1) <<< (ow - 1)) - 1;
    mn = -mx - 1;
    ov = (v > mx);
    un = (v < mn);
    if (sat && ov)      v = mx;
    else if (sat && un) v = mn;
    d = v & ((longint'(1) <<< ow) - 1);
  endfunction

  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic beat(input logic [15:0] a0, input logic [15:0] a1,
                      input logic [15:0] b0, input logic [15:0] b1, input logic last);
    s_valid = 1'b1;
    s_a     = {a1, a0};
    s_b     = {b1, b0};
    s_last  = last;
    @(negedge clk);
    check("s_ready_accum", longint'(rdy), 64'hF);
    @(posedge clk);
    #1;
    acc_m = acc_m + prod(a0, b0) + prod(a1, b1);
    cnt_m++;
    if (last) begin
      sb.push_back('{acc: acc_m, cnt: cnt_m});
      acc_m = 0;
      cnt_m = 0;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic bubble();
    @(posedge clk);
    #1;
  endtask

  task automatic get_result(input string tag, input bit hold);
    int     lat;
    exp_t   e;
    longint d;
    bit     ov, un;
    lat = 0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge clk);
      if (vld[0]) lat = k;
    end
    check({tag, "_latency"}, lat, 3);
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    if (lat == 0) return;
    for (int i = 0; i < 4; i++) begin
      conv(e.acc, cfg_sh[i], cfg_ow[i], cfg_sat[i], cfg_rnd[i], d, ov, un);
      check($sformatf("%s_data%0d", tag, i), longint'(dat[i]), d);
      check($sformatf("%s_ovf%0d", tag, i), longint'(ovf[i]), longint'(ov));
      check($sformatf("%s_unf%0d", tag, i), longint'(unf[i]), longint'(un));
      check($sformatf("%s_cnt%0d", tag, i), longint'(cnt[i]), longint'(e.cnt));
    end
    check({tag, "_valid_all"}, longint'(vld), 64'hF);
    check({tag, "_s_ready_out"}, longint'(rdy[0]), 0);
    if (hold) begin
      conv(e.acc, cfg_sh[0], cfg_ow[0], cfg_sat[0], cfg_rnd[0], d, ov, un);
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check({tag, "_hold_data"}, longint'(data0), d);
        check({tag, "_hold_valid"}, longint'(vld[0]), 1);
        check({tag, "_hold_s_ready"}, longint'(rdy[0]), 0);
      end
      m_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, "_valid_cleared"}, longint'(vld), 0);
    check({tag, "_s_ready_after"}, longint'(rdy), 64'hF);
  endtask

  initial begin
    bit seen;
    acc_m   = 0;
    cnt_m   = 0;
    reset   = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_a     = '0;
    s_b     = '0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_s_ready", longint'(rdy), 64'hF);
    check("rst_m_valid", longint'(vld), 0);
    check("rst_m_data", longint'(data0), 0);
    check("rst_m_data_q8", longint'(data2), 0);
    check("rst_flags", longint'({ovf, unf}), 0);
    check("rst_m_count", longint'(cnt[0]), 0);

    // 1.0*0.5 + 2.0*0.25 = 1.0
    beat(16'h0100, 16'h0200, 16'h0080, 16'h0040, 1'b1);
    get_result("single", 1'b0);

    // positive overflow over 3 beats with bubbles in between
    beat(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0);
    bubble();
    beat(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0);
    bubble();
    bubble();
    beat(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
    get_result("ovf", 1'b0);

    for (int k = 0; k < 3; k++)
      beat(16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, (k == 2));
    get_result("unf", 1'b0);

    // half-LSB in Q.8: rounds up to 1, truncates to 0
    beat(16'h0001, 16'h0000, 16'h0080, 16'h0000, 1'b1);
    get_result("half_pos", 1'b0);

    // negative half-LSB: rounds to 0, truncates toward -inf to -1
    beat(16'hFFFF, 16'h0000, 16'h0080, 16'h0000, 1'b1);
    get_result("half_neg", 1'b0);

    m_ready = 1'b0;
    beat(16'h0300, 16'hFE00, 16'h0100, 16'h0080, 1'b0);
    beat(16'h0040, 16'h0010, 16'hFF00, 16'h0200, 1'b1);
    get_result("hold", 1'b1);
    beat(16'h0100, 16'h0000, 16'h0100, 16'h0000, 1'b1);
    get_result("back2back", 1'b0);

    // reset after 2 of 4 beats discards the partial vector
    beat(16'h1000, 16'h1000, 16'h1000, 16'h1000, 1'b0);
    beat(16'h1000, 16'h1000, 16'h1000, 16'h1000, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    acc_m = 0;
    cnt_m = 0;
    seen  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (vld != 0) seen = 1'b1;
    end
    check("midrst_no_valid", longint'(seen), 0);
    check("midrst_s_ready", longint'(rdy), 64'hF);
    @(posedge clk);
    #1;
    beat(16'h0200, 16'h0100, 16'h0300, 16'hFF00, 1'b1);
    get_result("after_rst", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_dot_lanes.md
MAC_DOT_LANES -- requirements
Module: mac_dot_lanes

Interface
REQ-001 SHALL have parameter LANES, default 4: multiply lanes per beat (1..16).
REQ-002 SHALL have parameters A_INT/A_FRAC, default 8/8, and B_INT/B_FRAC, default 8/8: signed fixed-point input formats.
REQ-003 SHALL have parameters OUT_INT/OUT_FRAC, default 16/16: signed result format; A_FRAC+B_FRAC >= OUT_FRAC is required.
REQ-004 SHALL have parameter GUARD_BITS, default 9: accumulator headroom above the lane-sum width.
REQ-005 SHALL have parameter SAT_EN, default 1: 1 saturates the result, 0 wraps it.
REQ-006 SHALL have parameter ROUND_EN, default 0: 1 rounds half-up, 0 truncates toward -inf.
REQ-007 SHALL have parameter CNT_W, default 16: beat-counter width.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-009 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have port s_valid, input, 1 bit: input beat valid.
REQ-011 SHALL have port s_ready, output, 1 bit: input beat accepted when s_valid and s_ready are both high.
REQ-012 SHALL have port s_last, input, 1 bit: the beat is the final beat of its vector.
REQ-013 SHALL have port s_a, input, LANES*(A_INT+A_FRAC) bits: packed A operands, lane 0 in the LSBs.
REQ-014 SHALL have port s_b, input, LANES*(B_INT+B_FRAC) bits: packed B operands, lane 0 in the LSBs.
REQ-015 SHALL have port m_data, output, OUT_INT+OUT_FRAC bits: dot-product result.
REQ-016 SHALL have port m_valid, output, 1 bit: result valid.
REQ-017 SHALL have port m_ready, input, 1 bit: downstream accepts the result.
REQ-018 SHALL have port m_overflow, output, 1 bit: result exceeded the positive output range.
REQ-019 SHALL have port m_underflow, output, 1 bit: result was below the negative output range.
REQ-020 SHALL have port m_count, output, CNT_W bits: beats accepted in the vector, saturating at all-ones.

Function
REQ-021 SHALL register all per-lane products in stage 1 (PW=A_INT+A_FRAC+B_INT+B_FRAC, PF=A_FRAC+B_FRAC), then in stage 2 add the lane sum into an accumulator of width PW+clog2(LANES)+GUARD_BITS that wraps modulo its width.
REQ-022 SHALL use the FSM states ACCUM, DRAIN and OUT.
REQ-023 In ACCUM, s_ready SHALL be 1.
REQ-024 An accepted beat with s_last=1 SHALL move the FSM from ACCUM to DRAIN.
REQ-025 DRAIN SHALL last 2 cycles, flushing the pipeline; s_ready SHALL be 0 throughout.
REQ-026 From DRAIN the FSM SHALL enter OUT and load m_data, the flags and m_count, with m_valid=1 and s_ready=0.
REQ-027 In OUT, the m_valid && m_ready handshake SHALL clear m_valid, clear the accumulator and counter, and return the FSM to ACCUM; s_ready SHALL be 1 on the next cycle.
REQ-028 Latency SHALL be 3 cycles: a last beat accepted at cycle T gives m_valid=1 at T+3.
REQ-029 A single-beat vector SHALL be legal and SHALL have the same latency.
REQ-030 Beats with s_valid=0 SHALL be bubbles that leave the accumulator unchanged; the pipeline SHALL keep any in-flight data.
REQ-031 Output conversion SHALL shift right by SH=PF-OUT_FRAC; when ROUND_EN=1 and SH>0 it SHALL first add 2^(SH-1).
REQ-032 If the converted value is above the output maximum, SHALL set m_overflow=1 and output 0x7F..F when SAT_EN=1, or the low bits when SAT_EN=0.
REQ-033 If the converted value is below the output minimum, SHALL set m_underflow=1 and output 0x80..0 when SAT_EN=1, or the low bits when SAT_EN=0.
REQ-034 Saturation SHALL also apply to any overflow caused by rounding.
REQ-035 While m_valid=1 and m_ready=0, m_data, the flags and m_count SHALL stay stable.
REQ-036 m_ready SHALL be ignored outside OUT.

Reset
REQ-037 When reset=1 at a clock edge, the next cycle SHALL have state ACCUM, all pipeline registers, accumulator and counter at 0, s_ready=1, m_valid=0, m_data=0, m_overflow=0, m_underflow=0 and m_count=0.
REQ-038 Reset mid-vector or in OUT SHALL discard partial or pending results without emitting m_valid.

Verification
REQ-039 Defaults, LANES=2: beat a=(0x0100,0x0200), b=(0x0080,0x0040), last=1 -> m_data=0x00010000 at T+3, flags 0, m_count=1.
REQ-040 LANES=2: 3 beats, all operands 0x7FFF, SAT_EN=1 -> m_data=0x7FFFFFFF, m_overflow=1, m_count=3; with SAT_EN=0 -> m_data=0x7FFA0006, m_overflow=1.
REQ-041 LANES=2: 3 beats, a=0x8000 and b=0x7FFF on every lane, SAT_EN=1 -> m_data=0x80000000, m_underflow=1.
REQ-042 OUT_FRAC=8, LANES=2: a=(0x0001,0), b=(0x0080,0) -> m_data=0x000001 when ROUND_EN=1, 0x000000 when ROUND_EN=0.
REQ-043 m_ready held 0 for 5 cycles in OUT -> m_data stable and s_ready=0; after the handshake, s_ready=1 and an immediate back-to-back vector accumulates from 0.
REQ-044 reset pulsed after 2 of 4 beats -> no m_valid; a following 1-beat vector yields only its own product.
